instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Fetch/decode/writeback sequencer directly upstream of alu. Reads 32-bit instruction words from a
//  synchronous ROM, holds a register file, drives alu op/a/b, captures alu result/status on writeback.
//  Turns the standalone ALU into a runnable single-issue, non-pipelined datapath.
// PARAMETERS
//  w         8   data word width; must match alu w
//  op_w      1   alu op width; must match alu op_w
//  status_w  1   alu status width; bit 0 is the branch flag
//  iw        32  instruction width; fixed format below needs 32
//  pc_w      8   program counter / rom address width
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         synchronous, active-high
//  start       in   1         1-cycle pulse: run from pc=0; honoured only in IDLE or HALT
//  rom_addr    out  pc_w      = pc (registered)
//  rom_data    in   iw        ROM word at rom_addr, valid 1 cycle after rom_addr presented
//  alu_op      out  op_w      registered
//  alu_a       out  w         registered
//  alu_b       out  w         registered
//  alu_result  in   w         combinational ALU result
//  alu_status  in   status_w  combinational ALU status
//  busy        out  1         high in FETCH/DECODE/EXEC
//  halted      out  1         high in HALT
//  dbg_addr    in   4         register index for bench readback
//  dbg_data    out  w         combinational regs[dbg_addr]
// BEHAVIOUR
//  Format: [31:28] class, [27:24] op (low op_w bits used), [23:20] rd, [19:16] ra, [15:12] rb, [7:0] imm/target.
//  Classes: 0 NOP, 1 ALU, 2 LDI, 3 JMP, 4 BRS, F HALT; every other class executes as NOP.
//  Reset: state IDLE; pc, rom_addr, alu_op, alu_a, alu_b, flag, all 16 regs = 0; busy = halted = 0.
//  States: IDLE -start-> FETCH -> DECODE -> (EXEC | FETCH | HALT); EXEC -> FETCH; HALT -start-> FETCH.
//  FETCH: rom_addr = pc; no other effect.
//  DECODE: rom_data valid; latch ir.
//   NOP: pc+1 -> FETCH.
//   LDI: regs[rd] <= imm (zero-extend if w>8, low w bits if w<8); pc+1 -> FETCH.
//   JMP: pc <= target[pc_w-1:0] -> FETCH.
//   BRS: pc <= flag ? target : pc+1 -> FETCH.
//   HALT: pc unchanged -> HALT.
//   ALU: alu_a <= regs[ra], alu_b <= regs[rb], alu_op <= op -> EXEC.
//  EXEC: alu inputs stable for the cycle; at its end regs[rd] <= alu_result, flag <= alu_status[0], pc+1 -> FETCH.
//  Latency per instr: ALU 3 cycles; all others 2 cycles (fetch+decode).
//  Operands read in DECODE, so rd==ra/rb uses old values; no hazards (one instr in flight).
//  pc arithmetic mod 2^pc_w: 2^pc_w-1 + 1 wraps to 0.
//  alu_op/a/b hold their last values outside EXEC; flag changes only in EXEC.
//  start in FETCH/DECODE/EXEC ignored. start in HALT: pc <= 0, regs and flag retained.
//  reset at any cycle, incl. mid-EXEC, wins: writeback suppressed, all reset values restored next edge.
// STRUCTURE
//  Shared header isa_defs.vh: class codes, field bit positions, state encodings.
//  Sub-module reg_file: 16 x w, 2 comb read ports + dbg read port, 1 sync write port, sync reset to 0.
//  Sequencer FSM, pc, ir and alu output registers stay in this module; alu is instantiated beside it by the top.
// TESTING
//  Reset held 2 cycles -> all outputs 0, busy=halted=0, rom_addr=0x00, dbg_data=0 for every index.
//  ROM {LDI r1,0x02; LDI r2,0x06; ALU op0 r3,r1,r2; HALT}, start -> in EXEC a=0x02,b=0x06,op=0;
//   dbg r3 == alu_result; halted rises exactly 9 cycles after first FETCH; rom_addr=0x03 in HALT.
//  ROM[0]=JMP 0xFF, ROM[0xFF]=NOP, ROM[0x00] revisited -> rom_addr sequence 00,FF,00.
//  BRS 0x10 with flag=0 -> rom_addr 0x01; after ALU setting status[0]=1, BRS 0x10 -> rom_addr 0x10.
//  Reset asserted during EXEC of ALU r3 -> r3 stays 0, pc=0, state IDLE; next start reruns from 0x00.
//  Start pulsed during DECODE ignored; class 0x7 word advances pc by 1 with no register change.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - instruction format, class codes and FSM states for the sequencer
package instr_sequencer_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    localparam logic [3:0] CLS_NOP  = 4'h0;
    localparam logic [3:0] CLS_ALU  = 4'h1;
    localparam logic [3:0] CLS_LDI  = 4'h2;
    localparam logic [3:0] CLS_JMP  = 4'h3;
    localparam logic [3:0] CLS_BRS  = 4'h4;
    localparam logic [3:0] CLS_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic [3:0] cls;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rsvd;
        logic [7:0] imm;
    } instr_t;

    function automatic instr_t decode_word(input logic [31:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/instr_sequencer_reg_file.sv
// rtl/instr_sequencer_reg_file.sv - 16-entry register file, two operand read ports, one debug read port
module instr_sequencer_reg_file
    import instr_sequencer_pkg::*;
#(
    parameter int w = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [w-1:0]      wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [w-1:0]      ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [w-1:0]      rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [w-1:0]      dbg_data
);

    logic [w-1:0] regs [NUM_REGS];

    // Reset has priority so a writeback in the reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/writeback sequencer driving an external combinational alu
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int w        = 8,
    parameter int op_w     = 1,
    parameter int status_w = 1,
    parameter int iw       = 32,
    parameter int pc_w     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [pc_w-1:0]     rom_addr,
    input  logic [iw-1:0]       rom_data,
    output logic [op_w-1:0]     alu_op,
    output logic [w-1:0]        alu_a,
    output logic [w-1:0]        alu_b,
    input  logic [w-1:0]        alu_result,
    input  logic [status_w-1:0] alu_status,
    output logic                busy,
    output logic                halted,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [w-1:0]        dbg_data
);

    state_e            state_q, state_d;
    logic [pc_w-1:0]   pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [op_w-1:0]   op_q, op_d;
    logic [w-1:0]      a_q, a_d;
    logic [w-1:0]      b_q, b_d;
    logic              flag_q, flag_d;

    instr_t            word;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [w-1:0]      rf_wdata;
    logic [w-1:0]      ra_data;
    logic [w-1:0]      rb_data;

    assign word = decode_word(rom_data[31:0]);

    instr_sequencer_reg_file #(.w(w)) u_reg_file (
        .clock    (clock),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (word.ra),
        .ra_data  (ra_data),
        .rb_addr  (word.rb),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        flag_d   = flag_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q.rd;
        rf_wdata = alu_result;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = word;
                state_d = ST_FETCH;
                pc_d    = pc_q + pc_w'(1);
                case (word.cls)
                    CLS_NOP: begin
                    end
                    CLS_ALU: begin
                        // Operands sampled here, so rd aliasing ra/rb sees pre-writeback values.
                        a_d     = ra_data;
                        b_d     = rb_data;
                        op_d    = word.op[op_w-1:0];
                        pc_d    = pc_q;
                        state_d = ST_EXEC;
                    end
                    CLS_LDI: begin
                        rf_we    = 1'b1;
                        rf_waddr = word.rd;
                        rf_wdata = w'(word.imm);
                    end
                    CLS_JMP: begin
                        pc_d = pc_w'(word.imm);
                    end
                    CLS_BRS: begin
                        if (flag_q) begin
                            pc_d = pc_w'(word.imm);
                        end
                    end
                    CLS_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            ST_EXEC: begin
                rf_we   = 1'b1;
                flag_d  = alu_status[0];
                pc_d    = pc_q + pc_w'(1);
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_addr = pc_q;
    assign alu_op   = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALT);

    logic unused_bits;
    assign unused_bits = ^{ir_q, alu_status, rom_data};

endmodule
